// File: rtl/id_operand_stage_pkg.sv
// Shared constants and types for the ID operand stage.
//   - Bus widths for the IF->ID, bypass->ID and ID->EXE buses.
//   - Opcode ranges that make source 2 come from rd instead of rk
//     (branches and st.b/st.h/st.w).
//   - bypass_t: one stage's slice of the bypass bus, MSB first.
//   - src2IsRd(): decides which field feeds source 2.
package id_operand_stage_pkg;

  localparam int IF_TO_ID_BUS_WD  = 64;
  localparam int BY_TO_ID_BUS_WD  = 120;
  localparam int ID_TO_EXE_BUS_WD = 128;
  localparam int BY_STAGE_WD      = 40;

  localparam logic [5:0] OP6_BR_LO  = 6'h16;
  localparam logic [5:0] OP6_BR_HI  = 6'h1b;
  localparam logic [9:0] OP10_ST_LO = 10'h0a4;
  localparam logic [9:0] OP10_ST_HI = 10'h0a6;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        dataValid;
    logic        valid;
    logic        wEn;
  } bypass_t;

  // Branches compare rj against rd, and stores take their data from rd,
  // so both read rd as their second source.
  function automatic logic src2IsRd(input logic [31:0] inst);
    logic isBranch;
    logic isStore;
    isBranch = (inst[31:26] >= OP6_BR_LO) && (inst[31:26] <= OP6_BR_HI);
    isStore  = (inst[31:22] >= OP10_ST_LO) && (inst[31:22] <= OP10_ST_HI);
    return isBranch | isStore;
  endfunction

endpackage

// File: rtl/id_operand_stage_fwd_mux.sv
// operand_fwd_mux: resolves one source operand.
// Ports:
//   src_addr_i  source register number
//   rf_data_i   regfile read data for that register
//   exe_by_i / mem_by_i / wb_by_i  bypass slices {addr, data, data_valid, valid, w_en}
//   operand_o   resolved operand value
//   stall_o     the newest producer has not produced its value yet
module operand_fwd_mux
  import id_operand_stage_pkg::*;
(
  input  logic [4:0]             src_addr_i,
  input  logic [31:0]            rf_data_i,
  input  logic [BY_STAGE_WD-1:0] exe_by_i,
  input  logic [BY_STAGE_WD-1:0] mem_by_i,
  input  logic [BY_STAGE_WD-1:0] wb_by_i,
  output logic [31:0]            operand_o,
  output logic                   stall_o
);

  bypass_t exeBy;
  bypass_t memBy;
  bypass_t wbBy;
  logic    exeHit;
  logic    memHit;
  logic    wbHit;

  assign exeBy = exe_by_i;
  assign memBy = mem_by_i;
  assign wbBy  = wb_by_i;

  assign exeHit = exeBy.valid & exeBy.wEn & (exeBy.addr == src_addr_i);
  assign memHit = memBy.valid & memBy.wEn & (memBy.addr == src_addr_i);
  assign wbHit  = wbBy.valid  & wbBy.wEn  & (wbBy.addr  == src_addr_i);

  // The youngest writer (EXE) holds the newest value, so once a stage hits,
  // older stages are ignored even if they have data ready. r0 is hardwired
  // to zero and never waits on anyone.
  always_comb begin
    operand_o = rf_data_i;
    stall_o   = 1'b0;
    if (src_addr_i == 5'd0) begin
      operand_o = '0;
    end else if (exeHit) begin
      operand_o = exeBy.dataValid ? exeBy.data : '0;
      stall_o   = ~exeBy.dataValid;
    end else if (memHit) begin
      operand_o = memBy.dataValid ? memBy.data : '0;
      stall_o   = ~memBy.dataValid;
    end else if (wbHit) begin
      operand_o = wbBy.dataValid ? wbBy.data : '0;
      stall_o   = ~wbBy.dataValid;
    end
  end

endmodule

// File: rtl/id_operand_stage.sv
// id_operand_stage: instruction decode / operand stage.
// Latches {pc, inst} from IF, reads the regfile, resolves both operands
// through the EXE/MEM/WB bypass bus and hands them to EXE with a
// valid/allowin handshake. Stalls while a matching producer's data is not
// ready yet (load-use).
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   IF_to_ID_valid / _bus         incoming {pc, inst}
//   ID_allowin                    ID can take a new instruction
//   EXE_allowin                   EXE can take an instruction
//   ID_to_EXE_valid / _bus        outgoing {pc, inst, src1, src2}
//   br_flush                      redirect from EXE, kills ID content
//   BY_to_ID_bus                  bypass info, EXE slice in the MSBs
//   rf_raddr1/2, rf_rdata1/2      regfile read ports
//   stall_cnt                     saturating count of stall cycles
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int CNT_WD = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        IF_to_ID_valid,
  input  logic [IF_TO_ID_BUS_WD-1:0]  IF_to_ID_bus,
  output logic                        ID_allowin,
  input  logic                        EXE_allowin,
  output logic                        ID_to_EXE_valid,
  output logic [ID_TO_EXE_BUS_WD-1:0] ID_to_EXE_bus,
  input  logic                        br_flush,
  input  logic [BY_TO_ID_BUS_WD-1:0]  BY_to_ID_bus,
  output logic [4:0]                  rf_raddr1,
  output logic [4:0]                  rf_raddr2,
  input  logic [31:0]                 rf_rdata1,
  input  logic [31:0]                 rf_rdata2,
  output logic [CNT_WD-1:0]           stall_cnt
);

  logic                       idValid_q,  idValid_d;
  logic [IF_TO_ID_BUS_WD-1:0] idBus_q,    idBus_d;
  logic [CNT_WD-1:0]          stallCnt_q, stallCnt_d;

  logic [31:0] pc;
  logic [31:0] inst;
  logic [4:0]  src1Addr;
  logic [4:0]  src2Addr;
  logic [31:0] src1Data;
  logic [31:0] src2Data;
  logic        stall1;
  logic        stall2;
  logic        readyGo;

  assign pc   = idBus_q[63:32];
  assign inst = idBus_q[31:0];

  assign src1Addr  = inst[9:5];
  assign src2Addr  = src2IsRd(inst) ? inst[4:0] : inst[14:10];
  assign rf_raddr1 = src1Addr;
  assign rf_raddr2 = src2Addr;

  operand_fwd_mux u_fwd1 (
    .src_addr_i (src1Addr),
    .rf_data_i  (rf_rdata1),
    .exe_by_i   (BY_to_ID_bus[119:80]),
    .mem_by_i   (BY_to_ID_bus[79:40]),
    .wb_by_i    (BY_to_ID_bus[39:0]),
    .operand_o  (src1Data),
    .stall_o    (stall1)
  );

  operand_fwd_mux u_fwd2 (
    .src_addr_i (src2Addr),
    .rf_data_i  (rf_rdata2),
    .exe_by_i   (BY_to_ID_bus[119:80]),
    .mem_by_i   (BY_to_ID_bus[79:40]),
    .wb_by_i    (BY_to_ID_bus[39:0]),
    .operand_o  (src2Data),
    .stall_o    (stall2)
  );

  assign readyGo         = ~(stall1 | stall2);
  assign ID_allowin      = ~idValid_q | (readyGo & EXE_allowin);
  assign ID_to_EXE_valid = idValid_q & readyGo & ~br_flush;
  assign ID_to_EXE_bus   = {pc, inst, src1Data, src2Data};
  assign stall_cnt       = stallCnt_q;

  // Next-state for the stage register. A flush beats everything; otherwise
  // the held instruction only moves when ID_allowin says so, which keeps
  // pc/inst stable during a stall and means IF simply keeps presenting.
  always_comb begin
    idValid_d = idValid_q;
    idBus_d   = idBus_q;
    if (br_flush) begin
      idValid_d = 1'b0;
    end else if (ID_allowin) begin
      idValid_d = IF_to_ID_valid;
      if (IF_to_ID_valid) begin
        idBus_d = IF_to_ID_bus;
      end
    end
  end

  // Stall counter: a cycle killed by a flush is not counted; the count
  // sticks at all-ones instead of wrapping.
  always_comb begin
    stallCnt_d = stallCnt_q;
    if (idValid_q & ~readyGo & ~br_flush & ~(&stallCnt_q)) begin
      stallCnt_d = stallCnt_q + 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      idValid_q  <= 1'b0;
      idBus_q    <= '0;
      stallCnt_q <= '0;
    end else begin
      idValid_q  <= idValid_d;
      idBus_q    <= idBus_d;
      stallCnt_q <= stallCnt_d;
    end
  end

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed testbench for id_operand_stage. Inputs are driven just after
// the rising edge; outputs are checked on the falling edge.
module tb_id_operand_stage;

  logic         clk;
  logic         reset;
  logic         IF_to_ID_valid;
  logic [63:0]  IF_to_ID_bus;
  logic         ID_allowin;
  logic         EXE_allowin;
  logic         ID_to_EXE_valid;
  logic [127:0] ID_to_EXE_bus;
  logic         br_flush;
  logic [119:0] BY_to_ID_bus;
  logic [4:0]   rf_raddr1;
  logic [4:0]   rf_raddr2;
  logic [31:0]  rf_rdata1;
  logic [31:0]  rf_rdata2;
  logic [31:0]  stall_cnt;

  int total;
  int bad;

  id_operand_stage #(.CNT_WD(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .IF_to_ID_valid  (IF_to_ID_valid),
    .IF_to_ID_bus    (IF_to_ID_bus),
    .ID_allowin      (ID_allowin),
    .EXE_allowin     (EXE_allowin),
    .ID_to_EXE_valid (ID_to_EXE_valid),
    .ID_to_EXE_bus   (ID_to_EXE_bus),
    .br_flush        (br_flush),
    .BY_to_ID_bus    (BY_to_ID_bus),
    .rf_raddr1       (rf_raddr1),
    .rf_raddr2       (rf_raddr2),
    .rf_rdata1       (rf_rdata1),
    .rf_rdata2       (rf_rdata2),
    .stall_cnt       (stall_cnt)
  );

  // Regfile model: register n reads as 0xA000_00nn.
  assign rf_rdata1 = 32'hA000_0000 | {27'd0, rf_raddr1};
  assign rf_rdata2 = 32'hA000_0000 | {27'd0, rf_raddr2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction encodings used below.
  localparam logic [31:0] INST_ADD_1_4_6  = 32'h0010_1881; // add.w r1,r4,r6
  localparam logic [31:0] INST_ADD_2_5_0  = 32'h0010_00A2; // add.w r2,r5,r0
  localparam logic [31:0] INST_ADD_3_0_8  = 32'h0010_2003; // add.w r3,r0,r8
  localparam logic [31:0] INST_STW_7_9    = 32'h2980_0127; // st.w r7,r9,0
  localparam logic [31:0] INST_ADD_1_10_11 = 32'h0010_2D41; // add.w r1,r10,r11
  localparam logic [31:0] INST_BEQ_12_13  = 32'h5800_158D; // op 0x16, rj=12, rd=13, [14:10]=5
  localparam logic [31:0] INST_OP1B       = 32'h6C00_1443; // op 0x1b, rj=2, rd=3, [14:10]=5
  localparam logic [31:0] INST_OP1C       = 32'h7000_1443; // op 0x1c, rk=5
  localparam logic [31:0] INST_OP0A7      = 32'h29C0_0C41; // [31:22]=0x0a7, rk=3, rd=1

  function automatic logic [39:0] mkBy(input logic [4:0] addr, input logic [31:0] data,
                                       input logic dv, input logic v, input logic we);
    return {addr, data, dv, v, we};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ifValid, input logic [63:0] ifBus,
                               input logic exeAllow, input logic flush,
                               input logic [119:0] by);
    IF_to_ID_valid = ifValid;
    IF_to_ID_bus   = ifBus;
    EXE_allowin    = exeAllow;
    br_flush       = flush;
    BY_to_ID_bus   = by;
  endtask

  task automatic toNeg();
    @(negedge clk);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for one cycle with an idle bypass bus.
  task automatic loadInst(input logic [31:0] pc, input logic [31:0] inst);
    applyStimulus(1'b1, {pc, inst}, 1'b1, 1'b0, '0);
    nextCycle();
    IF_to_ID_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // 1: reset held two cycles with IF offering an instruction.
    reset = 1'b1;
    applyStimulus(1'b1, {32'h0000_0100, INST_ADD_1_4_6}, 1'b1, 1'b0, '0);
    nextCycle();
    nextCycle();
    toNeg();
    checkOutput("rst_valid",   {127'd0, ID_to_EXE_valid}, 128'd0);
    checkOutput("rst_allowin", {127'd0, ID_allowin},      128'd1);
    checkOutput("rst_cnt",     {96'd0, stall_cnt},        128'd0);
    nextCycle();
    reset = 1'b0;
    IF_to_ID_valid = 1'b0;
    nextCycle();

    // 2: EXE and MEM both write r4; EXE is newer and wins.
    loadInst(32'h0000_1000, INST_ADD_1_4_6);
    BY_to_ID_bus = {mkBy(5'd4, 32'h1234, 1'b1, 1'b1, 1'b1),
                    mkBy(5'd4, 32'h5555, 1'b1, 1'b1, 1'b1), 40'd0};
    toNeg();
    checkOutput("add_raddr", {118'd0, rf_raddr1, rf_raddr2}, {118'd0, 5'd4, 5'd6});
    checkOutput("add_valid", {127'd0, ID_to_EXE_valid}, 128'd1);
    checkOutput("add_bus", ID_to_EXE_bus,
                {32'h0000_1000, INST_ADD_1_4_6, 32'h0000_1234, 32'hA000_0006});
    nextCycle();
    BY_to_ID_bus = '0;
    toNeg();
    checkOutput("add_drained", {127'd0, ID_to_EXE_valid}, 128'd0);
    nextCycle();

    // 3: load-use on r5, IF keeps offering the next instruction meanwhile.
    loadInst(32'h0000_1004, INST_ADD_2_5_0);
    applyStimulus(1'b1, {32'h0000_1008, INST_ADD_3_0_8}, 1'b1, 1'b0,
                  {mkBy(5'd5, 32'hDEAD, 1'b0, 1'b1, 1'b1), 80'd0});
    toNeg();
    checkOutput("lu_valid",   {127'd0, ID_to_EXE_valid}, 128'd0);
    checkOutput("lu_allowin", {127'd0, ID_allowin},      128'd0);
    nextCycle();
    BY_to_ID_bus = {40'd0, mkBy(5'd5, 32'hCAFE, 1'b1, 1'b1, 1'b1), 40'd0};
    toNeg();
    checkOutput("lu_cnt",   {96'd0, stall_cnt}, 128'd1);
    checkOutput("lu_issue", {126'd0, ID_to_EXE_valid, ID_allowin}, 128'd3);
    checkOutput("lu_bus", ID_to_EXE_bus,
                {32'h0000_1004, INST_ADD_2_5_0, 32'h0000_CAFE, 32'h0000_0000});
    nextCycle();

    // 4: r0 source while EXE "writes" r0 with pending data.
    IF_to_ID_valid = 1'b0;
    BY_to_ID_bus = {mkBy(5'd0, 32'h7777, 1'b0, 1'b1, 1'b1),
                    mkBy(5'd8, 32'h8888, 1'b1, 1'b1, 1'b1), 40'd0};
    toNeg();
    checkOutput("r0_valid", {127'd0, ID_to_EXE_valid}, 128'd1);
    checkOutput("r0_bus", ID_to_EXE_bus,
                {32'h0000_1008, INST_ADD_3_0_8, 32'h0000_0000, 32'h0000_8888});
    nextCycle();

    // 5: st.w reads rd as src2; WB-only hit, then EXE back-pressure with no hit.
    loadInst(32'h0000_1010, INST_STW_7_9);
    applyStimulus(1'b0, '0, 1'b1, 1'b0,
                  {mkBy(5'd7, 32'h1111, 1'b1, 1'b1, 1'b0),
                   mkBy(5'd7, 32'h2222, 1'b1, 1'b0, 1'b1),
                   mkBy(5'd7, 32'hBEEF, 1'b1, 1'b1, 1'b1)});
    EXE_allowin = 1'b0;
    toNeg();
    checkOutput("st_raddr2", {123'd0, rf_raddr2}, 128'd7);
    checkOutput("st_bus", ID_to_EXE_bus,
                {32'h0000_1010, INST_STW_7_9, 32'hA000_0009, 32'h0000_BEEF});
    checkOutput("st_hold", {126'd0, ID_to_EXE_valid, ID_allowin}, 128'd2);
    nextCycle();
    BY_to_ID_bus = '0;
    EXE_allowin  = 1'b1;
    toNeg();
    checkOutput("st_rf", ID_to_EXE_bus,
                {32'h0000_1010, INST_STW_7_9, 32'hA000_0009, 32'hA000_0007});
    checkOutput("st_cnt", {96'd0, stall_cnt}, 128'd1);
    nextCycle();

    // src2 select at the opcode range edges.
    loadInst(32'h0000_1020, INST_BEQ_12_13);
    toNeg();
    checkOutput("br16_raddr", {118'd0, rf_raddr1, rf_raddr2}, {118'd0, 5'd12, 5'd13});
    nextCycle();
    loadInst(32'h0000_1024, INST_OP1B);
    toNeg();
    checkOutput("br1b_raddr2", {123'd0, rf_raddr2}, 128'd3);
    nextCycle();
    loadInst(32'h0000_1028, INST_OP1C);
    toNeg();
    checkOutput("op1c_raddr2", {123'd0, rf_raddr2}, 128'd5);
    nextCycle();
    loadInst(32'h0000_102C, INST_OP0A7);
    toNeg();
    checkOutput("op0a7_raddr2", {123'd0, rf_raddr2}, 128'd3);
    nextCycle();

    // 6: flush during a stall.
    loadInst(32'h0000_1030, INST_ADD_1_10_11);
    BY_to_ID_bus = {mkBy(5'd11, 32'h0, 1'b0, 1'b1, 1'b1), 80'd0};
    toNeg();
    checkOutput("fl_stall", {127'd0, ID_to_EXE_valid}, 128'd0);
    nextCycle();
    br_flush = 1'b1;
    IF_to_ID_valid = 1'b1;
    IF_to_ID_bus   = {32'h0000_1034, INST_ADD_1_4_6};
    toNeg();
    checkOutput("fl_valid", {127'd0, ID_to_EXE_valid}, 128'd0);
    checkOutput("fl_cnt_a", {96'd0, stall_cnt},        128'd2);
    nextCycle();
    br_flush = 1'b0;
    IF_to_ID_valid = 1'b0;
    toNeg();
    checkOutput("fl_empty", {126'd0, ID_to_EXE_valid, ID_allowin}, 128'd1);
    checkOutput("fl_cnt_b", {96'd0, stall_cnt}, 128'd2);
    nextCycle();

    // Reset in the middle of a stall.
    loadInst(32'h0000_1040, INST_ADD_2_5_0);
    BY_to_ID_bus = {mkBy(5'd5, 32'h0, 1'b0, 1'b1, 1'b1), 80'd0};
    nextCycle();
    toNeg();
    checkOutput("rs_cnt_pre", {96'd0, stall_cnt}, 128'd3);
    nextCycle();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    toNeg();
    checkOutput("rs_empty", {126'd0, ID_to_EXE_valid, ID_allowin}, 128'd1);
    checkOutput("rs_cnt",   {96'd0, stall_cnt}, 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
